// File: rtl/gl_prim_assembler.sv
// Primitive assembler: turns a vertex stream into list/strip/fan triangles,
// drops degenerate ones, and hands each survivor to the rasterizer with a
// one-cycle fifo_ready pulse. It then waits for raster_ready before taking
// more vertices.
module gl_prim_assembler #(
    parameter int VERTEX_TYPE_SIZE = 96,
    parameter int CNT_W            = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [1:0]                  mode,
    input  logic                        vtx_valid,
    output logic                        vtx_ready,
    input  logic [VERTEX_TYPE_SIZE-1:0] vtx_data,
    input  logic                        vtx_last,
    output logic                        fifo_ready,
    output logic [VERTEX_TYPE_SIZE-1:0] fifo_in1,
    output logic [VERTEX_TYPE_SIZE-1:0] fifo_in2,
    output logic [VERTEX_TYPE_SIZE-1:0] fifo_in3,
    input  logic                        raster_ready,
    output logic [CNT_W-1:0]            tri_count,
    output logic [CNT_W-1:0]            cull_count
);

    typedef enum logic [1:0] {COLLECT = 2'd0, ISSUE = 2'd1, WAIT = 2'd2} state_t;

    localparam logic [1:0] M_LIST  = 2'd0;
    localparam logic [1:0] M_STRIP = 2'd1;
    localparam logic [1:0] M_FAN   = 2'd2;

    state_t                      state, state_nxt;
    logic [VERTEX_TYPE_SIZE-1:0] slot_a, slot_b;
    logic [1:0]                  vcnt;
    logic                        parity;
    logic [1:0]                  lmode;

    logic                        accept;
    logic [1:0]                  mode_sel, eff_mode;
    logic                        have_tri, degen, fire, cull;
    logic [VERTEX_TYPE_SIZE-1:0] c1, c2, c3;

    // Two vertices collapse when both x and y match bit for bit; attr is ignored.
    function automatic logic same_pos(input logic [VERTEX_TYPE_SIZE-1:0] p,
                                      input logic [VERTEX_TYPE_SIZE-1:0] q);
        return (p[VERTEX_TYPE_SIZE-1 -: 32] == q[VERTEX_TYPE_SIZE-1 -: 32]) &&
               (p[63:32] == q[63:32]);
    endfunction

    assign accept = vtx_valid & vtx_ready;

    // Candidate triangle and cull decision for the vertex being offered now.
    // The first vertex of a primitive uses the live mode; later vertices use
    // the mode latched when that first vertex was accepted.
    always_comb begin
        mode_sel = (vcnt == 2'd0) ? mode : lmode;
        eff_mode = (mode_sel == 2'd3) ? M_LIST : mode_sel;
        have_tri = accept && (vcnt == 2'd2);
        // Odd strip triangles swap the first two vertices to keep a consistent winding.
        if (eff_mode == M_STRIP && parity) begin
            c1 = slot_b;
            c2 = slot_a;
        end else begin
            c1 = slot_a;
            c2 = slot_b;
        end
        c3    = vtx_data;
        degen = same_pos(c1, c2) | same_pos(c1, c3) | same_pos(c2, c3);
        fire  = have_tri & ~degen;
        cull  = have_tri & degen;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= COLLECT;
        else     state <= state_nxt;
    end

    // FSM next state: raster_ready only matters once we are in WAIT.
    always_comb begin
        state_nxt = state;
        case (state)
            COLLECT: if (fire) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (raster_ready) state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    // FSM outputs.
    always_comb begin
        vtx_ready  = (state == COLLECT);
        fifo_ready = (state == ISSUE);
    end

    // Vertex slots, primitive bookkeeping, triangle output registers, counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_a     <= '0;
            slot_b     <= '0;
            vcnt       <= 2'd0;
            parity     <= 1'b0;
            lmode      <= 2'd0;
            fifo_in1   <= '0;
            fifo_in2   <= '0;
            fifo_in3   <= '0;
            tri_count  <= '0;
            cull_count <= '0;
        end else begin
            if (state == ISSUE) tri_count <= tri_count + 1'b1;
            if (accept) begin
                if (vcnt == 2'd0) lmode <= mode;
                case (vcnt)
                    2'd0: begin
                        slot_a <= vtx_data;
                        vcnt   <= 2'd1;
                    end
                    2'd1: begin
                        slot_b <= vtx_data;
                        vcnt   <= 2'd2;
                    end
                    default: begin
                        // Sliding window: strips shift both slots, fans keep the pivot.
                        case (eff_mode)
                            M_STRIP: begin
                                slot_a <= slot_b;
                                slot_b <= vtx_data;
                                parity <= ~parity;
                            end
                            M_FAN:   slot_b <= vtx_data;
                            default: vcnt   <= 2'd0;
                        endcase
                    end
                endcase
                if (fire) begin
                    fifo_in1 <= c1;
                    fifo_in2 <= c2;
                    fifo_in3 <= c3;
                end
                if (cull) cull_count <= cull_count + 1'b1;
                // End of primitive: a partial triangle is simply forgotten.
                if (vtx_last) begin
                    vcnt   <= 2'd0;
                    parity <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_gl_prim_assembler.sv
// Scoreboard bench for gl_prim_assembler: directed vertex streams push the
// hand-derived triangles into a queue; a monitor pops and compares on each
// fifo_ready pulse, and a responder returns raster_ready 3 cycles later.
module tb_gl_prim_assembler;

    localparam int VW = 96;
    localparam int CW = 16;

    typedef struct {
        logic [VW-1:0] v1;
        logic [VW-1:0] v2;
        logic [VW-1:0] v3;
    } tri_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    mode;
    logic          vtx_valid;
    logic          vtx_ready;
    logic [VW-1:0] vtx_data;
    logic          vtx_last;
    logic          fifo_ready;
    logic [VW-1:0] fifo_in1, fifo_in2, fifo_in3;
    logic          raster_ready;
    logic [CW-1:0] tri_count, cull_count;

    int   checks = 0;
    int   errors = 0;
    tri_t exp_q[$];
    logic prev_fr = 1'b0;

    logic [VW-1:0] v [1:7];
    logic [VW-1:0] v1p;

    gl_prim_assembler #(.VERTEX_TYPE_SIZE(VW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .mode(mode),
        .vtx_valid(vtx_valid), .vtx_ready(vtx_ready),
        .vtx_data(vtx_data), .vtx_last(vtx_last),
        .fifo_ready(fifo_ready), .fifo_in1(fifo_in1), .fifo_in2(fifo_in2), .fifo_in3(fifo_in3),
        .raster_ready(raster_ready), .tri_count(tri_count), .cull_count(cull_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [VW-1:0] a, input logic [VW-1:0] b, input logic [VW-1:0] c);
        tri_t t;
        t.v1 = a; t.v2 = b; t.v3 = c;
        exp_q.push_back(t);
    endtask

    // Offer one vertex and hold it until the DUT takes it (bounded).
    task automatic send(input logic [VW-1:0] d, input logic last);
        int n;
        @(negedge clk);
        vtx_valid = 1'b1;
        vtx_data  = d;
        vtx_last  = last;
        n = 0;
        while (!vtx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!vtx_ready) begin
            checks++; errors++;
            $display("FAIL send_timeout: vtx_ready stuck at %b, required 1", vtx_ready);
            vtx_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            vtx_valid = 1'b0;
            vtx_last  = 1'b0;
            vtx_data  = '0;
        end
    endtask

    // Wait until all expected triangles are consumed and the block is collecting again.
    task automatic drain();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(exp_q.size() == 0 && vtx_ready) && n < 300);
        if (!(exp_q.size() == 0 && vtx_ready)) begin
            checks++; errors++;
            $display("FAIL drain_timeout: pending=%0d vtx_ready=%b, required 0 and 1", exp_q.size(), vtx_ready);
        end
    endtask

    // Monitor: compare each presented triangle against the scoreboard head.
    always @(negedge clk) begin
        if (rst) begin
            prev_fr = 1'b0;
        end else begin
            if (fifo_ready) begin
                chk("fifo_ready_single_cycle", {95'd0, prev_fr}, '0);
                chk("vtx_ready_low_in_issue", {95'd0, vtx_ready}, '0);
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_tri: got %h %h %h expected none", fifo_in1, fifo_in2, fifo_in3);
                end else begin
                    tri_t t;
                    t = exp_q.pop_front();
                    chk("tri_v1", fifo_in1, t.v1);
                    chk("tri_v2", fifo_in2, t.v2);
                    chk("tri_v3", fifo_in3, t.v3);
                end
            end
            prev_fr = fifo_ready;
        end
    end

    // Rasterizer model: acknowledge each triangle three cycles after its pulse.
    initial begin
        raster_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (fifo_ready && !rst) begin
                repeat (3) @(negedge clk);
                raster_ready = 1'b1;
                @(negedge clk);
                raster_ready = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time %0t exceeded, required completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 1; i <= 7; i++)
            v[i] = {32'(i * 32'h100), 32'(i * 32'h10 + 1), 32'hA000 + 32'(i)};
        v1p = {v[1][95:32], 32'hBEEF};

        rst = 1'b1; mode = 2'd0; vtx_valid = 1'b0; vtx_data = '0; vtx_last = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_fifo_ready", {95'd0, fifo_ready}, '0);
        chk("reset_vtx_ready", {95'd0, vtx_ready}, 96'd1);
        chk("reset_fifo_in1", fifo_in1, '0);
        chk("reset_tri_count", {80'd0, tri_count}, '0);
        chk("reset_cull_count", {80'd0, cull_count}, '0);
        rst = 1'b0;

        // Triangle list
        mode = 2'd0;
        push(v[1], v[2], v[3]);
        push(v[4], v[5], v[6]);
        for (int i = 1; i <= 6; i++) send(v[i], i == 6);
        drain();
        chk("list_tri_count", {80'd0, tri_count}, 96'd2);

        // Strip: winding alternates
        mode = 2'd1;
        push(v[1], v[2], v[3]);
        push(v[3], v[2], v[4]);
        push(v[3], v[4], v[5]);
        for (int i = 1; i <= 5; i++) send(v[i], i == 5);
        drain();
        chk("strip_tri_count", {80'd0, tri_count}, 96'd5);

        // Fan: pivot stays V1
        mode = 2'd2;
        push(v[1], v[2], v[3]);
        push(v[1], v[3], v[4]);
        push(v[1], v[4], v[5]);
        for (int i = 1; i <= 5; i++) send(v[i], i == 5);
        drain();
        chk("fan_tri_count", {80'd0, tri_count}, 96'd8);

        // Degenerate triangle is dropped, next one goes through
        mode = 2'd0;
        send(v[1], 1'b0);
        send(v[2], 1'b0);
        send(v1p, 1'b0);
        @(negedge clk);
        chk("cull_count", {80'd0, cull_count}, 96'd1);
        chk("cull_vtx_ready", {95'd0, vtx_ready}, 96'd1);
        push(v[4], v[5], v[6]);
        send(v[4], 1'b0);
        send(v[5], 1'b0);
        send(v[6], 1'b1);
        drain();
        chk("after_cull_tri_count", {80'd0, tri_count}, 96'd9);

        // Partial primitive discarded; mid-primitive mode change ignored
        mode = 2'd0;
        send(v[1], 1'b0);
        send(v[2], 1'b1);
        push(v[3], v[4], v[5]);
        send(v[3], 1'b0);
        mode = 2'd2;
        send(v[4], 1'b0);
        send(v[5], 1'b1);
        drain();
        chk("partial_tri_count", {80'd0, tri_count}, 96'd10);
        chk("partial_cull_count", {80'd0, cull_count}, 96'd1);

        // Reset while waiting on the rasterizer
        mode = 2'd0;
        push(v[1], v[2], v[3]);
        send(v[1], 1'b0);
        send(v[2], 1'b0);
        send(v[3], 1'b1);
        for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(negedge clk);
        chk("pre_reset_popped", 96'(exp_q.size()), '0);
        @(negedge clk);
        chk("pre_reset_in_wait", {95'd0, vtx_ready}, '0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_fifo_ready", {95'd0, fifo_ready}, '0);
        chk("async_rst_fifo_in1", fifo_in1, '0);
        chk("async_rst_fifo_in2", fifo_in2, '0);
        chk("async_rst_fifo_in3", fifo_in3, '0);
        chk("async_rst_tri_count", {80'd0, tri_count}, '0);
        chk("async_rst_cull_count", {80'd0, cull_count}, '0);
        chk("async_rst_vtx_ready", {95'd0, vtx_ready}, 96'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("post_reset_vtx_ready", {95'd0, vtx_ready}, 96'd1);
        chk("post_reset_tri_count", {80'd0, tri_count}, '0);
        push(v[4], v[5], v[6]);
        send(v[4], 1'b0);
        send(v[5], 1'b0);
        send(v[6], 1'b1);
        drain();
        chk("post_reset_issue_count", {80'd0, tri_count}, 96'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/gl_prim_assembler.md
Name: gl_prim_assembler

Overview:
- Sits directly upstream of gl_rasterizer.
- Accepts a stream of 96-bit vertices (x[95:64], y[63:32], attr[31:0], x/y IEEE-754 single) from the vertex/transform stage.
- Assembles them into triangles per the primitive mode (list, strip, fan) and drops degenerate triangles.
- Presents each surviving triangle on fifo_in1..3 with a one-cycle fifo_ready pulse, then holds until the rasterizer signals completion on raster_ready.

Parameters:
VERTEX_TYPE_SIZE, 96, vertex word width; x at [95:64], y at [63:32]
CNT_W, 16, width of tri_count/cull_count statistics counters

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
mode  input  2  primitive mode: 0 triangles, 1 strip, 2 fan, 3 reserved (treated as 0)
vtx_valid  input  1  upstream vertex valid
vtx_ready  output  1  block can accept a vertex this cycle
vtx_data  input  VERTEX_TYPE_SIZE  vertex word
vtx_last  input  1  vertex ends the current primitive
fifo_ready  output  1  one-cycle pulse: triangle valid on fifo_in1..3
fifo_in1  output  VERTEX_TYPE_SIZE  triangle vertex 1
fifo_in2  output  VERTEX_TYPE_SIZE  triangle vertex 2
fifo_in3  output  VERTEX_TYPE_SIZE  triangle vertex 3
raster_ready  input  1  rasterizer finished current triangle (one-cycle pulse per triangle)
tri_count  output  CNT_W  triangles issued, wraps
cull_count  output  CNT_W  degenerate triangles dropped, wraps

Behaviour:
- Reset (async, any time incl. mid-primitive or WAIT):
  - state=COLLECT; fifo_ready=0; fifo_in1..3=0; tri_count=0; cull_count=0.
  - Vertex slots A/B cleared; vcnt=0; parity=0; latched mode=0.
  - Any pending triangle is lost.
- vtx_ready = (state==COLLECT), combinational from state; 1 immediately after reset. Accept = vtx_valid & vtx_ready.
- Mode latching: mode is sampled on accept when vcnt==0. Changes while vcnt!=0 are ignored until the primitive ends.
- States:
  - COLLECT: accept vertices. A triangle-completing accept moves to ISSUE, or stays in COLLECT if the triangle is culled.
  - ISSUE: fifo_ready=1 for exactly this cycle, outputs stable; go to WAIT.
  - WAIT: fifo_in1..3 held. raster_ready high → COLLECT next cycle. raster_ready seen in ISSUE is ignored.
- Assembly on accept of new vertex N (vcnt counts vertices in the current primitive, saturates at 2):
  - Triangles:
    - vcnt 0 → A=N.
    - vcnt 1 → B=N.
    - vcnt 2 → tri (A,B,N); vcnt=0.
  - Strip:
    - vcnt<2 → fill A, then B.
    - Else tri = parity ? (B,A,N) : (A,B,N), preserving winding. Then A=B, B=N, parity toggles.
  - Fan:
    - vcnt<2 → fill A (pivot), then B.
    - Else tri (A,B,N); B=N; A unchanged.
- Degenerate cull (combinational on the candidate): if any pair has bit-equal x and bit-equal y, drop the triangle.
  - cull_count++; no fifo_ready; stay in COLLECT.
  - Strip/fan slot updates and parity toggle still occur.
- Latency: triangle-completing accept at cycle T → fifo_in1..3 registered and fifo_ready high at T+1; vtx_ready low from T+1. raster_ready at cycle M (M≥T+2) → vtx_ready high at M+1.
- tri_count increments in the ISSUE cycle and wraps at 2^CNT_W.
- vtx_last on an accepted vertex: after processing that vertex (including any triangle formed), vcnt=0 and parity=0. A partial primitive (fewer than 3 vertices) is discarded silently.
- Vertices with vtx_valid low are never consumed. vtx_data/vtx_last are sampled only on accept.

Test Plan:
- Mode 0, vertices V1..V6 (distinct x/y) with V6 last, raster_ready pulsed 3 cycles after each fifo_ready → two triangles (V1,V2,V3),(V4,V5,V6); tri_count=2; each fifo_ready exactly 1 cycle; vtx_ready low from the issue cycle until the cycle after raster_ready.
- Mode 1, V1..V5, last on V5 → triangles (V1,V2,V3),(V3,V2,V4),(V3,V4,V5); tri_count=3.
- Mode 2, V1..V5 → triangles (V1,V2,V3),(V1,V3,V4),(V1,V4,V5).
- Mode 0, V1,V2,V1' (V1' has the same x/y as V1, different attr) → no fifo_ready; cull_count=1; vtx_ready stays 1; next three valid vertices issue normally.
- Mode 0, V1,V2 with last on V2, then V3,V4,V5 → only (V3,V4,V5) issued; mode toggled to 2 after V3 has no effect.
- rst asserted during WAIT, held 2 cycles, without clock edges → all outputs 0 immediately; vtx_ready=1 after release; a stale raster_ready causes no issue.
